// File: rtl/prog_loader.sv
// Boot-time program loader: parses a framed byte stream, writes 9-bit words into
// instruction memory and releases the core's reset once the checksum matches.
module prog_loader #(
    parameter int unsigned D = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    output logic         in_ready,
    output logic         wr_en,
    output logic [D-1:0] wr_addr,
    output logic [8:0]   wr_data,
    output logic         cpu_reset,
    output logic         load_done,
    output logic         load_err,
    output logic [D-1:0] words_loaded
);

    localparam int unsigned CW = 12;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CNT_LO = 3'd1;
    localparam logic [2:0] S_CNT_HI = 3'd2;
    localparam logic [2:0] S_W_LO   = 3'd3;
    localparam logic [2:0] S_W_HI   = 3'd4;
    localparam logic [2:0] S_CHK    = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] S_ERR    = 3'd7;

    logic [2:0]    state, state_nxt;
    logic [CW-1:0] count, count_nxt;
    logic [7:0]    acc, acc_nxt;
    logic [7:0]    lo_byte, lo_byte_nxt;
    logic          in_ready_nxt;
    logic          wr_en_nxt;
    logic [D-1:0]  wr_addr_nxt;
    logic [8:0]    wr_data_nxt;
    logic          cpu_reset_nxt;
    logic          load_done_nxt;
    logic          load_err_nxt;
    logic [D-1:0]  words_nxt;
    logic [D-1:0]  words_inc;
    logic [CW-1:0] cnt_full;
    logic          hs;

    assign hs        = in_valid && in_ready;
    assign words_inc = words_loaded + D'(1);
    assign cnt_full  = {in_data[3:0], count[7:0]};

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            count        <= '0;
            acc          <= '0;
            lo_byte      <= '0;
            in_ready     <= 1'b0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            cpu_reset    <= 1'b1;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
        end else begin
            state        <= state_nxt;
            count        <= count_nxt;
            acc          <= acc_nxt;
            lo_byte      <= lo_byte_nxt;
            in_ready     <= in_ready_nxt;
            wr_en        <= wr_en_nxt;
            wr_addr      <= wr_addr_nxt;
            wr_data      <= wr_data_nxt;
            cpu_reset    <= cpu_reset_nxt;
            load_done    <= load_done_nxt;
            load_err     <= load_err_nxt;
            words_loaded <= words_nxt;
        end
    end

    // Frame parser: next state and next output values
    always_comb begin
        state_nxt     = state;
        count_nxt     = count;
        acc_nxt       = acc;
        lo_byte_nxt   = lo_byte;
        wr_en_nxt     = 1'b0;
        wr_addr_nxt   = wr_addr;
        wr_data_nxt   = wr_data;
        cpu_reset_nxt = cpu_reset;
        load_done_nxt = load_done;
        load_err_nxt  = load_err;
        words_nxt     = words_loaded;

        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_nxt     = S_CNT_LO;
                    count_nxt     = '0;
                    acc_nxt       = '0;
                    words_nxt     = '0;
                    load_done_nxt = 1'b0;
                    load_err_nxt  = 1'b0;
                    cpu_reset_nxt = 1'b1;
                end
            end
            S_CNT_LO: begin
                if (hs) begin
                    count_nxt = {count[CW-1:8], in_data};
                    state_nxt = S_CNT_HI;
                end
            end
            S_CNT_HI: begin
                if (hs) begin
                    if (in_data[7:4] != 4'h0) begin
                        state_nxt    = S_ERR;
                        load_err_nxt = 1'b1;
                    end else begin
                        count_nxt = cnt_full;
                        state_nxt = (cnt_full == CW'(0)) ? S_CHK : S_W_LO;
                    end
                end
            end
            S_W_LO: begin
                if (hs) begin
                    lo_byte_nxt = in_data;
                    acc_nxt     = acc + in_data;
                    state_nxt   = S_W_HI;
                end
            end
            S_W_HI: begin
                if (hs) begin
                    acc_nxt = acc + in_data;
                    if (in_data[7:1] != 7'd0) begin
                        state_nxt    = S_ERR;
                        load_err_nxt = 1'b1;
                    end else begin
                        wr_en_nxt   = 1'b1;
                        wr_addr_nxt = words_loaded;
                        wr_data_nxt = {in_data[0], lo_byte};
                        words_nxt   = words_inc;
                        state_nxt   = (words_inc == D'(count)) ? S_CHK : S_W_LO;
                    end
                end
            end
            S_CHK: begin
                if (hs) begin
                    if (in_data == acc) begin
                        state_nxt     = S_DONE;
                        load_done_nxt = 1'b1;
                        cpu_reset_nxt = 1'b0;
                    end else begin
                        state_nxt     = S_ERR;
                        load_err_nxt  = 1'b1;
                        cpu_reset_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // Ready is a decode of the upcoming state so it never depends on in_valid
        in_ready_nxt = (state_nxt >= S_CNT_LO) && (state_nxt <= S_CHK);
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: drives framed byte streams and checks writes and status.
module tb_prog_loader;

    localparam int unsigned D = 12;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_ready;
    logic         wr_en;
    logic [D-1:0] wr_addr;
    logic [8:0]   wr_data;
    logic         cpu_reset;
    logic         load_done;
    logic         load_err;
    logic [D-1:0] words_loaded;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_wr     = 0;
    logic [D-1:0] log_addr [0:63];
    logic [8:0]   log_data [0:63];
    int           log_cyc  [0:63];
    logic [7:0]   frame    [0:15];
    logic [8:0]   exp_d    [0:2];

    prog_loader #(.D(D)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .cpu_reset(cpu_reset), .load_done(load_done),
        .load_err(load_err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write log sampled mid-cycle
    always @(negedge clk) begin
        if (wr_en && n_wr < 64) begin
            log_addr[n_wr] = wr_addr;
            log_data[n_wr] = wr_data;
            log_cyc[n_wr]  = cyc;
            n_wr = n_wr + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Presents one byte and returns at the negedge after its handshake
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int waited;
        in_valid = 1'b1;
        in_data  = b;
        waited   = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("handshake_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        if (gap) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int len, input bit gap);
        for (int i = 0; i < len; i++) send_byte(frame[i], gap);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ready_after_start", 32'(in_ready), 32'd1);
    endtask

    task automatic set_three(input logic [7:0] chk_byte);
        frame[0] = 8'h03; frame[1] = 8'h00;
        frame[2] = 8'hA5; frame[3] = 8'h01;
        frame[4] = 8'h03; frame[5] = 8'h00;
        frame[6] = 8'hFF; frame[7] = 8'h00;
        frame[8] = chk_byte;
    endtask

    task automatic check_three(input int base, input bit full_rate);
        check("write_count", 32'(n_wr - base), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check("write_addr", 32'(log_addr[base + i]), 32'(i));
            check("write_data", 32'(log_data[base + i]), 32'(exp_d[i]));
        end
        if (full_rate) begin
            check("write_spacing_0", 32'(log_cyc[base + 1] - log_cyc[base]), 32'd2);
            check("write_spacing_1", 32'(log_cyc[base + 2] - log_cyc[base + 1]), 32'd2);
        end
        check("words_loaded", 32'(words_loaded), 32'd3);
    endtask

    initial begin
        int base;
        exp_d[0] = 9'h1A5; exp_d[1] = 9'h003; exp_d[2] = 9'h0FF;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state and idle hold
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_err", 32'(load_err), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        for (int i = 0; i < 10; i++) begin
            check("idle_cpu_reset", 32'(cpu_reset), 32'd1);
            check("idle_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end

        // Good 3-word load at full rate
        set_three(8'hA8);
        base = n_wr;
        do_start();
        send_frame(9, 1'b0);
        check_three(base, 1'b1);
        check("full_done", 32'(load_done), 32'd1);
        check("full_err", 32'(load_err), 32'd0);
        check("full_cpu_reset", 32'(cpu_reset), 32'd0);
        check("full_in_ready", 32'(in_ready), 32'd0);
        repeat (3) @(negedge clk);
        check("done_no_extra_write", 32'(n_wr - base), 32'd3);

        // Same stream with in_valid toggling
        base = n_wr;
        do_start();
        check("restart_clears_done", 32'(load_done), 32'd0);
        check("restart_cpu_reset", 32'(cpu_reset), 32'd1);
        send_frame(9, 1'b1);
        check_three(base, 1'b0);
        check("gap_done", 32'(load_done), 32'd1);
        check("gap_cpu_reset", 32'(cpu_reset), 32'd0);

        // Bad checksum
        set_three(8'hA9);
        base = n_wr;
        do_start();
        send_frame(9, 1'b0);
        check_three(base, 1'b1);
        check("badchk_err", 32'(load_err), 32'd1);
        check("badchk_done", 32'(load_done), 32'd0);
        check("badchk_cpu_reset", 32'(cpu_reset), 32'd1);
        check("badchk_in_ready", 32'(in_ready), 32'd0);

        // CNT_HI framing error
        frame[0] = 8'h03; frame[1] = 8'h10;
        base = n_wr;
        do_start();
        check("restart_clears_err", 32'(load_err), 32'd0);
        send_frame(2, 1'b0);
        check("cnthi_err", 32'(load_err), 32'd1);
        check("cnthi_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(negedge clk);
        check("cnthi_writes", 32'(n_wr - base), 32'd0);

        // W_HI framing error on the second word
        set_three(8'h00);
        frame[5] = 8'h03;
        base = n_wr;
        do_start();
        send_frame(6, 1'b0);
        check("whi_err", 32'(load_err), 32'd1);
        repeat (2) @(negedge clk);
        check("whi_writes", 32'(n_wr - base), 32'd1);
        check("whi_words", 32'(words_loaded), 32'd1);
        check("whi_cpu_reset", 32'(cpu_reset), 32'd1);

        // Zero-length image
        frame[0] = 8'h00; frame[1] = 8'h00; frame[2] = 8'h00;
        base = n_wr;
        do_start();
        send_frame(3, 1'b0);
        check("zero_done", 32'(load_done), 32'd1);
        check("zero_cpu_reset", 32'(cpu_reset), 32'd0);
        check("zero_writes", 32'(n_wr - base), 32'd0);
        check("zero_words", 32'(words_loaded), 32'd0);

        // Reset mid-load, then a full reload
        set_three(8'hA8);
        base = n_wr;
        do_start();
        send_frame(5, 1'b0);
        check("mid_words", 32'(words_loaded), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_wr_en", 32'(wr_en), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("midrst_words", 32'(words_loaded), 32'd0);
        repeat (3) @(negedge clk);
        check("midrst_writes", 32'(n_wr - base), 32'd1);
        check("midrst_stays_idle", 32'(in_ready), 32'd0);
        base = n_wr;
        do_start();
        send_frame(9, 1'b0);
        check_three(base, 1'b1);
        check("reload_done", 32'(load_done), 32'd1);
        check("reload_cpu_reset", 32'(cpu_reset), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader for the 9-bit single-cycle core. It receives a framed byte stream (word count, 9-bit machine-code words, additive checksum) over a valid/ready interface and writes each word into the writable instruction memory that feeds `mach_code`. It holds the core in reset until the image is complete and verified. It is the write side of the instruction fetch path; the core's fetch is the read side.

## Interface
- `D`, 12: instruction address width; must match the program counter width.
- `clk`  in  1: single clock.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: begin a load; sampled only in IDLE, DONE or ERR.
- `in_valid`  in  1: byte-stream source has a byte.
- `in_data`  in  8: stream byte.
- `in_ready`  out  1: loader accepts a byte; transfer when `in_valid && in_ready`.
- `wr_en`  out  1: instruction memory write strobe.
- `wr_addr`  out  D: write address.
- `wr_data`  out  9: machine-code word.
- `cpu_reset`  out  1: core reset; high until a verified load completes.
- `load_done`  out  1: level, image loaded and checksum matched.
- `load_err`  out  1: level, framing or checksum error.
- `words_loaded`  out  D: words written so far.

## Operation
- Frame, in byte order: CNT_LO, CNT_HI, then per word {W_LO = word[7:0], W_HI = {7'b0, word[8]}}, then CHK.
- Word count N = {CNT_HI[3:0], CNT_LO}. CNT_HI[7:4] must be 0.
- FSM states: IDLE, CNT_LO, CNT_HI, W_LO, W_HI, CHK, DONE, ERR.
- IDLE, DONE or ERR with `start`=1: go to CNT_LO; clear `words_loaded`, checksum accumulator, `load_done` and `load_err`; drive `cpu_reset`=1.
- CNT_LO: accept a byte and go to CNT_HI.
- CNT_HI: accept a byte. If [7:4]≠0, go to ERR. If N=0, go to CHK. Otherwise go to W_LO.
- W_LO: accept a byte; latch it; add it to the accumulator (mod 256); go to W_HI.
- W_HI: accept a byte; add it to the accumulator.
  - If [7:1]≠0, go to ERR and issue no write.
  - Otherwise issue a write of {byte[0], latched W_LO} at address `words_loaded`, then increment `words_loaded`.
  - If the incremented count equals N, go to CHK; otherwise go to W_LO.
- CHK: accept a byte. If it equals the accumulator, go to DONE; otherwise go to ERR.
- DONE: `load_done`=1, `cpu_reset`=0, `in_ready`=0.
- ERR: `load_err`=1, `cpu_reset`=1, `in_ready`=0. Words already written stay in memory.
- `start` is ignored in CNT_LO through CHK.
- `in_ready` = 1 exactly in states CNT_LO through CHK. It is a registered state decode, not combinational on `in_valid`.
- No stalls are generated internally. Source backpressure (`in_valid`=0) holds the current state indefinitely.

## Timing
- Reset values: state IDLE, `in_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `cpu_reset`=1, `load_done`=0, `load_err`=0, `words_loaded`=0.
- `reset` has priority over every other input. Reset during a load abandons it: the next cycle is IDLE, `wr_en`=0, and no partial write is issued.
- Cycle of `start` in IDLE → `in_ready`=1 on the next cycle.
- Maximum rate is one byte per cycle, so a full frame takes 2N+3 accepted bytes.
- W_HI handshake on cycle t → `wr_en`=1 for exactly one cycle at t+1, with `wr_addr` and `wr_data` valid at t+1. `words_loaded` shows the new value at t+1.
- `wr_en` is 0 in every other cycle. Consecutive words can produce writes two cycles apart.
- CHK handshake on cycle t → at t+1, `load_done` or `load_err` is 1 and `cpu_reset` reflects the final state.
- Error on a CNT_HI or W_HI handshake at t → `load_err`=1 at t+1.
- `wr_addr` wraps at 2^D only if N=2^D−1+1. That case is impossible because N ≤ 4095 < 2^12.
- `start` asserted in the same cycle as a final CHK handshake is ignored, because the state is not yet DONE.

## Test plan
- Reset, then idle: all outputs hold their reset values; `cpu_reset`=1 and `in_ready`=0 for 10 cycles.
- Load 3 words with stream 03,00,A5,01,03,00,FF,00,A8 at full rate:
  - `wr_en` pulses at addresses 0,1,2 with data 0x1A5, 0x003, 0x0FF.
  - `words_loaded`=3, `load_done`=1, `cpu_reset`=0.
- Same stream with `in_valid` toggling every other cycle: identical writes and final state, and no write while `in_valid`=0.
- Same stream with checksum byte A9: three writes occur, then `load_err`=1, `load_done`=0, `cpu_reset` stays 1.
- Framing errors:
  - CNT_HI=0x10 → ERR after byte 2 with no writes.
  - W_HI=0x03 → ERR and no write for that word.
- Zero-length and reset cases:
  - Stream 00,00,00 → DONE with no writes.
  - Reset asserted after byte 5 of the 3-word stream → IDLE with `wr_en`=0. A subsequent `start` plus the full stream loads correctly.
